// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle for sram_port_arbiter: per-requester command inputs,
// one-hot grant and tagged read-return outputs.
interface sram_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 256
);
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ-1:0]        i_lock;
  logic [NUM_REQ-1:0]        i_we;
  logic [NUM_REQ*ADDR_W-1:0] i_addr;
  logic [NUM_REQ*DATA_W-1:0] i_wdata;
  logic [NUM_REQ-1:0]        o_gnt;
  logic [NUM_REQ-1:0]        o_rvalid;
  logic [DATA_W-1:0]         o_rdata;

  modport master (
    output i_req, i_lock, i_we, i_addr, i_wdata,
    input  o_gnt, o_rvalid, o_rdata
  );

  modport slave (
    input  i_req, i_lock, i_we, i_addr, i_wdata,
    output o_gnt, o_rvalid, o_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port among NUM_REQ requesters, with
// burst lock, registered SRAM command and requester-tagged read return.
module sram_port_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  sram_port_arbiter_if.slave req_if,
  output logic [ADDR_W-1:0] o_sram_address,
  output logic              o_sram_wr_en,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_rdata
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TAG_W = RD_LAT * NUM_REQ;

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               lock_valid_q, lock_valid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               wr_en_q, wr_en_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

  logic               found;
  logic               gnt_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] new_tag;

  // Lock owner keeps the port while it still requests; otherwise search from ptr.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (lock_valid_q && req_if.i_req[owner_q]) begin
      found   = 1'b1;
      gnt_idx = owner_q;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
        if (!found && req_if.i_req[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    gnt_any = found & i_rstn;
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    lock_valid_d = 1'b0;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wdata_d      = wdata_q;
    new_tag      = '0;
    if (gnt_any) begin
      addr_d       = req_if.i_addr[gnt_idx*ADDR_W +: ADDR_W];
      wr_en_d      = req_if.i_we[gnt_idx];
      wdata_d      = req_if.i_wdata[gnt_idx*DATA_W +: DATA_W];
      ptr_d        = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      lock_valid_d = req_if.i_lock[gnt_idx];
      owner_d      = gnt_idx;
      new_tag      = req_if.i_we[gnt_idx] ? '0 : gnt;
    end
    // Tag pipeline is flattened: newest stage in the low bits, oldest feeds rvalid.
    tag_d    = (tag_q << NUM_REQ) | TAG_W'(new_tag);
    rvalid_d = tag_q[TAG_W-1 -: NUM_REQ];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr_q        <= '0;
      owner_q      <= '0;
      lock_valid_q <= 1'b0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wdata_q      <= '0;
      tag_q        <= '0;
      rvalid_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      lock_valid_q <= lock_valid_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wdata_q      <= wdata_d;
      tag_q        <= tag_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign req_if.o_gnt    = gnt;
  assign req_if.o_rvalid = rvalid_q;
  assign req_if.o_rdata  = i_sram_rdata;
  assign o_sram_address  = addr_q;
  assign o_sram_wr_en    = wr_en_q;
  assign o_sram_wdata    = wdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised and directed bench for sram_port_arbiter with an SRAM model and
// a transaction-level reference (grant rule, memory image, scheduled returns).
module tb_sram_port_arbiter;

  localparam int NR = 3;
  localparam int AW = 8;
  localparam int DW = 256;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) ifc ();

  logic [AW-1:0] sram_addr;
  logic          sram_we;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  sram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .req_if         (ifc),
    .o_sram_address (sram_addr),
    .o_sram_wr_en   (sram_we),
    .o_sram_wdata   (sram_wdata),
    .i_sram_rdata   (sram_rdata)
  );

  // SRAM: write at end of command cycle, read data RL cycles after the address cycle
  logic [DW-1:0] mem [256] = '{default: '0};
  logic [DW-1:0] rd1 = '0;
  logic [DW-1:0] rd2 = '0;
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    rd1 <= mem[sram_addr];
    rd2 <= rd1;
  end
  assign sram_rdata = rd2;

  int vectors = 0;
  int miscompares = 0;

  // stimulus
  logic          rstn_v;
  logic [NR-1:0] req_v, lock_v, we_v;
  logic [AW-1:0] addr_v [NR];
  logic [DW-1:0] wdata_v [NR];

  // reference model state
  logic [DW-1:0] ref_mem [256];
  int            m_ptr, m_owner, cyc;
  bit            m_lock;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  int            exp_tag [int];
  logic [DW-1:0] exp_dat [int];

  // per-cycle observations and expectations
  logic [NR-1:0] obs_gnt, obs_rv, exp_gnt, exp_rv;
  logic [DW-1:0] obs_rdata, exp_rdata, obs_wdata, exp_wdata;
  logic [AW-1:0] obs_addr, exp_addr;
  logic          obs_we, exp_we;
  int            exp_k;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_lock = 0;
    m_addr = '0; m_we = 1'b0; m_wdata = '0;
    exp_tag.delete();
    exp_dat.delete();
  endtask

  task automatic idle_inputs();
    req_v = '0; lock_v = '0; we_v = '0;
  endtask

  // One clock cycle: drive inputs, observe, predict, advance model across the edge.
  task automatic step();
    int k;
    rstn = rstn_v;
    ifc.i_req  = req_v;
    ifc.i_lock = lock_v;
    ifc.i_we   = we_v;
    for (int r = 0; r < NR; r++) begin
      ifc.i_addr[r*AW +: AW]  = addr_v[r];
      ifc.i_wdata[r*DW +: DW] = wdata_v[r];
    end
    if (!rstn_v) model_reset();
    #1;
    obs_gnt = ifc.o_gnt;  obs_rv = ifc.o_rvalid; obs_rdata = ifc.o_rdata;
    obs_addr = sram_addr; obs_we = sram_we;      obs_wdata = sram_wdata;

    k = -1;
    if (rstn_v) begin
      if (m_lock && req_v[m_owner]) k = m_owner;
      else
        for (int j = 0; j < NR; j++)
          if (k < 0 && req_v[(m_ptr + j) % NR]) k = (m_ptr + j) % NR;
    end
    exp_k = k;
    exp_gnt = '0;
    if (k >= 0) exp_gnt[k] = 1'b1;
    exp_rv = '0;
    exp_rdata = '0;
    if (exp_tag.exists(cyc)) begin
      exp_rv[exp_tag[cyc]] = 1'b1;
      exp_rdata = exp_dat[cyc];
      exp_tag.delete(cyc);
      exp_dat.delete(cyc);
    end
    exp_addr = m_addr; exp_we = m_we; exp_wdata = m_wdata;

    if (rstn_v) begin
      if (k >= 0) begin
        m_addr = addr_v[k]; m_we = we_v[k]; m_wdata = wdata_v[k];
        m_ptr = (k + 1) % NR; m_lock = lock_v[k]; m_owner = k;
        if (we_v[k]) ref_mem[addr_v[k]] = wdata_v[k];
        else begin
          exp_tag[cyc + 1 + RL] = k;
          exp_dat[cyc + 1 + RL] = ref_mem[addr_v[k]];
        end
      end else begin
        m_we = 1'b0;
        m_lock = 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn_v = 1'b0; req_v = 3'b111; lock_v = '0; we_v = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (obs_gnt !== 3'b000) begin miscompares++; $display("FAIL reset_gnt: got %b want 000", obs_gnt); end
      vectors++; if (obs_we !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", obs_we); end
      vectors++; if (obs_rv !== 3'b000) begin miscompares++; $display("FAIL reset_rvalid: got %b want 000", obs_rv); end
      vectors++; if (obs_addr !== 8'h00) begin miscompares++; $display("FAIL reset_addr: got %h want 00", obs_addr); end
    end
    rstn_v = 1'b1;
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] want;
    for (int r = 0; r < NR; r++) addr_v[r] = 8'(8'h40 + r);
    for (int i = 0; i < 10; i++) begin
      req_v = (i < 6) ? 3'b111 : 3'b000;
      we_v = '0; lock_v = '0;
      step();
      if (i < 6) begin
        want = 3'b001 << (i % 3);
        vectors++; if (obs_gnt !== want) begin miscompares++; $display("FAIL rr_order step %0d: got %b want %b", i, obs_gnt, want); end
      end
      if (i >= 1 + RL && i < 7 + RL) begin
        want = 3'b001 << ((i - 1 - RL) % 3);
        vectors++; if (obs_rv !== want) begin miscompares++; $display("FAIL rr_rvalid step %0d: got %b want %b", i, obs_rv, want); end
      end
      vectors++; if (obs_gnt !== exp_gnt) begin miscompares++; $display("FAIL rr_gnt_model step %0d: got %b want %b", i, obs_gnt, exp_gnt); end
      vectors++; if (obs_rv !== exp_rv) begin miscompares++; $display("FAIL rr_rv_model step %0d: got %b want %b", i, obs_rv, exp_rv); end
    end
  endtask

  task automatic test_single_read();
    idle_inputs();
    req_v = 3'b001; we_v = 3'b001; addr_v[0] = 8'h12; wdata_v[0] = {32{8'hA5}};
    step();
    vectors++; if (obs_gnt !== 3'b001) begin miscompares++; $display("FAIL sr_wr_gnt: got %b want 001", obs_gnt); end
    req_v = 3'b010; we_v = 3'b000; addr_v[1] = 8'h12;
    step();
    vectors++; if (obs_gnt !== 3'b010) begin miscompares++; $display("FAIL sr_rd_gnt: got %b want 010", obs_gnt); end
    vectors++; if (obs_we !== 1'b1 || obs_addr !== 8'h12) begin miscompares++; $display("FAIL sr_wr_cmd: got we=%b addr=%h want we=1 addr=12", obs_we, obs_addr); end
    idle_inputs();
    for (int j = 0; j <= RL; j++) begin
      step();
      if (j == RL) begin
        vectors++; if (obs_rv !== 3'b010) begin miscompares++; $display("FAIL sr_rvalid: got %b want 010", obs_rv); end
        vectors++; if (obs_rdata !== {32{8'hA5}}) begin miscompares++; $display("FAIL sr_rdata: got %h want a5..a5", obs_rdata); end
      end else begin
        vectors++; if (obs_rv !== 3'b000) begin miscompares++; $display("FAIL sr_early_rvalid j=%0d: got %b want 000", j, obs_rv); end
      end
    end
  endtask

  task automatic test_lock_burst();
    logic [NR-1:0] want;
    idle_inputs();
    addr_v[0] = 8'h20; addr_v[2] = 8'h22;
    for (int i = 0; i < 5; i++) begin
      req_v = 3'b101; we_v = '0;
      lock_v = (i < 3) ? 3'b100 : 3'b000;
      step();
      want = (i < 4) ? 3'b100 : 3'b001;
      vectors++; if (obs_gnt !== want) begin miscompares++; $display("FAIL lock_gnt step %0d: got %b want %b", i, obs_gnt, want); end
      vectors++; if (obs_gnt !== exp_gnt) begin miscompares++; $display("FAIL lock_gnt_model step %0d: got %b want %b", i, obs_gnt, exp_gnt); end
    end
    idle_inputs();
    for (int j = 0; j < RL + 2; j++) begin
      step();
      vectors++; if (obs_rv !== exp_rv) begin miscompares++; $display("FAIL lock_drain_rv j=%0d: got %b want %b", j, obs_rv, exp_rv); end
    end
  endtask

  task automatic test_idle_gap();
    idle_inputs();
    req_v = 3'b001; we_v = 3'b001; addr_v[0] = 8'h33; wdata_v[0] = rand_word();
    step();
    idle_inputs();
    step();
    vectors++; if (obs_we !== 1'b1) begin miscompares++; $display("FAIL idle_wr_cmd: got %b want 1", obs_we); end
    step();
    vectors++; if (obs_we !== 1'b0) begin miscompares++; $display("FAIL idle_wr_en: got %b want 0", obs_we); end
    vectors++; if (obs_addr !== 8'h33) begin miscompares++; $display("FAIL idle_addr_hold: got %h want 33", obs_addr); end
    vectors++; if (obs_gnt !== 3'b000) begin miscompares++; $display("FAIL idle_gnt: got %b want 000", obs_gnt); end
    req_v = 3'b011; addr_v[1] = 8'h34;
    step();
    vectors++; if (obs_gnt !== 3'b010) begin miscompares++; $display("FAIL idle_resume_gnt: got %b want 010", obs_gnt); end
    idle_inputs();
    for (int j = 0; j < RL + 2; j++) begin
      step();
      vectors++; if (obs_rv !== exp_rv) begin miscompares++; $display("FAIL idle_drain_rv j=%0d: got %b want %b", j, obs_rv, exp_rv); end
    end
  endtask

  task automatic test_random();
    bit pend [NR];
    for (int r = 0; r < NR; r++) pend[r] = 0;
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NR; r++) begin
        if (!pend[r] && ($urandom % 3 != 0)) begin
          pend[r] = 1;
          we_v[r] = ($urandom % 2) == 1;
          addr_v[r] = 8'($urandom % 16);
          wdata_v[r] = rand_word();
        end
        req_v[r] = pend[r];
        lock_v[r] = ($urandom % 4) == 0;
      end
      step();
      if (exp_k >= 0) pend[exp_k] = 0;
      vectors++; if (obs_gnt !== exp_gnt) begin miscompares++; $display("FAIL rnd_gnt cyc %0d: got %b want %b", i, obs_gnt, exp_gnt); end
      vectors++; if (obs_rv !== exp_rv) begin miscompares++; $display("FAIL rnd_rvalid cyc %0d: got %b want %b", i, obs_rv, exp_rv); end
      if (exp_rv != 0) begin
        vectors++; if (obs_rdata !== exp_rdata) begin miscompares++; $display("FAIL rnd_rdata cyc %0d: got %h want %h", i, obs_rdata, exp_rdata); end
      end
      vectors++; if (obs_addr !== exp_addr || obs_we !== exp_we) begin miscompares++; $display("FAIL rnd_cmd cyc %0d: got addr=%h we=%b want addr=%h we=%b", i, obs_addr, obs_we, exp_addr, exp_we); end
      vectors++; if (obs_wdata !== exp_wdata) begin miscompares++; $display("FAIL rnd_wdata cyc %0d: got %h want %h", i, obs_wdata, exp_wdata); end
    end
    idle_inputs();
    for (int j = 0; j < RL + 2; j++) begin
      step();
      vectors++; if (obs_rv !== exp_rv) begin miscompares++; $display("FAIL rnd_drain_rv j=%0d: got %b want %b", j, obs_rv, exp_rv); end
      if (exp_rv != 0) begin
        vectors++; if (obs_rdata !== exp_rdata) begin miscompares++; $display("FAIL rnd_drain_rdata j=%0d: got %h want %h", j, obs_rdata, exp_rdata); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    idle_inputs();
    req_v = 3'b001; addr_v[0] = 8'h12;
    step();
    vectors++; if (obs_gnt !== 3'b001) begin miscompares++; $display("FAIL rst_rd_gnt: got %b want 001", obs_gnt); end
    idle_inputs();
    rstn_v = 1'b0;
    req_v = 3'b111;
    step();
    vectors++; if (obs_gnt !== 3'b000) begin miscompares++; $display("FAIL rst_mid_gnt: got %b want 000", obs_gnt); end
    step();
    rstn_v = 1'b1;
    idle_inputs();
    for (int j = 0; j < 6; j++) begin
      step();
      vectors++; if (obs_rv !== 3'b000) begin miscompares++; $display("FAIL rst_mid_rvalid j=%0d: got %b want 000", j, obs_rv); end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ref_mem[a] = '0;
    for (int r = 0; r < NR; r++) begin
      addr_v[r] = '0;
      wdata_v[r] = '0;
    end
    cyc = 0;
    model_reset();
    rstn_v = 1'b0;
    rstn = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_single_read();
    test_lock_burst();
    test_idle_gap();
    test_random();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
